// File: rtl/insn_loader.sv
// insn_loader: boot loader that streams a word-count header plus little-endian
// payload into instruction memory, holding the CPU in reset until the image is complete.
module insn_loader #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic [3:0]            mem_wen_o,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  cpu_rstn_o,
    output logic                  done_o,
    output logic                  err_o
);
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR} state_t;

    // 17-bit so a full-capacity count compares correctly
    localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [16:0]           count_q, count_d;
    logic [16:0]           words_q, words_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           word_q, word_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  xfer;
    logic [16:0]           hdr_count;
    logic [16:0]           words_inc;

    assign byte_ready_o = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
    assign xfer         = byte_valid_i && byte_ready_o;
    assign hdr_count    = {1'b0, byte_i, count_q[7:0]};
    assign words_inc    = words_q + 17'd1;
    assign mem_wen_o    = {4{state_q == WRITE}};
    assign mem_waddr_o  = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign done_o       = state_q == DONE;
    assign err_o        = state_q == ERR;
    assign cpu_rstn_o   = state_q == DONE;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        words_d = words_q;
        addr_d  = addr_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, DONE, ERR: if (start_i) begin
                state_d = HDR0;
                count_d = '0;
                words_d = '0;
                addr_d  = '0;
                bcnt_d  = '0;
            end
            HDR0: if (xfer) begin
                count_d = {9'd0, byte_i};
                state_d = HDR1;
            end
            HDR1: if (xfer) begin
                count_d = hdr_count;
                state_d = (hdr_count == '0 || hdr_count > CAP) ? ERR : DATA;
            end
            // Lower three bytes shift in from the top; the fourth completes the word
            DATA: if (xfer) begin
                bcnt_d = bcnt_q + 2'd1;
                word_d = {byte_i, word_q[23:8]};
                if (bcnt_q == 2'd3) begin
                    wdata_d = {byte_i, word_q};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                words_d = words_inc;
                state_d = (words_inc == count_q) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            count_q <= '0;
            words_q <= '0;
            addr_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_insn_loader.sv
// tb_insn_loader: randomized loads against a word-list reference; a negedge monitor
// pops expected (address, word) pairs whenever the loader writes memory.
module tb_insn_loader;
    logic        clk_i = 0;
    logic        rstn_i = 0;
    logic        start_i = 0;
    logic [7:0]  byte_i = 0;
    logic        byte_valid_i = 0;
    logic        byte_ready_o;
    logic [3:0]  mem_wen_o;
    logic [11:0] mem_waddr_o;
    logic [31:0] mem_wdata_o;
    logic        cpu_rstn_o;
    logic        done_o;
    logic        err_o;

    insn_loader #(.ADDR_WIDTH(12)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .byte_i(byte_i),
        .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o), .mem_wen_o(mem_wen_o),
        .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o), .cpu_rstn_o(cpu_rstn_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        got;
    logic [7:0] pay[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (mem_wen_o !== 4'b0000) begin
            check("wen_pattern", 32'(mem_wen_o), 32'hf);
            check("ready_in_write", 32'(byte_ready_o), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", mem_waddr_o, mem_wdata_o);
            end else begin
                got = exp_q.pop_front();
                check("waddr", 32'(mem_waddr_o), 32'(got.a));
                check("wdata", mem_wdata_o, got.d);
            end
        end
    end

    // mode 0: continuous valid, 1: valid low every other cycle, 2: random gaps and stray starts
    task automatic send_byte(input logic [7:0] b, input int mode);
        int n = 0;
        if (mode == 1) begin
            byte_valid_i = 0;
            @(negedge clk_i);
        end else if (mode == 2) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid_i = 0;
                byte_i = 8'($urandom);
                @(negedge clk_i);
            end
            start_i = 1'($urandom_range(0, 1));
        end
        byte_i = b;
        byte_valid_i = 1;
        while (!byte_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (n == 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready 0 expected 1 within 20 cycles");
        end
        @(negedge clk_i);
        byte_valid_i = 0;
        start_i = 0;
    endtask

    task automatic fill_random(input int words, input bit addr_data);
        pay.delete();
        for (int i = 0; i < words; i++)
            for (int k = 0; k < 4; k++)
                pay.push_back(addr_data ? 8'((i >> (8 * k)) & 255) : 8'($urandom));
    endtask

    task automatic run_load(input int hdr, input int mode);
        int  t0;
        int  n = 0;
        bit  bad;
        logic [31:0] w;
        bad = (hdr == 0) || (hdr > 4096);
        start_i = 1;
        t0 = cyc;
        @(negedge clk_i);
        start_i = 0;
        check("ready_after_start", 32'(byte_ready_o), 1);
        check("cpu_rstn_in_load", 32'(cpu_rstn_o), 0);
        check("done_cleared", 32'(done_o), 0);
        check("err_cleared", 32'(err_o), 0);
        send_byte(8'(hdr & 255), mode);
        send_byte(8'((hdr >> 8) & 255), mode);
        if (!bad) begin
            for (int i = 0; i < hdr; i++) begin
                w = 0;
                for (int k = 0; k < 4; k++) w = w + (32'(pay[4 * i + k]) << (8 * k));
                exp_q.push_back('{a: 12'(i), d: w});
            end
            for (int i = 0; i < 4 * hdr; i++) send_byte(pay[i], mode);
        end
        while (!done_o && !err_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("done", 32'(done_o), 32'(!bad));
        check("err", 32'(err_o), 32'(bad));
        check("cpu_rstn", 32'(cpu_rstn_o), 32'(!bad));
        check("ready_at_end", 32'(byte_ready_o), 0);
        check("pending_writes", 32'(exp_q.size()), 0);
        if (mode == 0 && !bad) check("latency", 32'(cyc - t0), 32'(3 + 5 * hdr));
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        check("rst_ready", 32'(byte_ready_o), 0);
        check("rst_wen", 32'(mem_wen_o), 0);
        check("rst_waddr", 32'(mem_waddr_o), 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_cpu_rstn", 32'(cpu_rstn_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        rstn_i = 1;
        @(negedge clk_i);

        pay = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        run_load(2, 0);
        run_load(2, 1);
        run_load(0, 0);
        run_load(4097, 2);
        for (int r = 0; r < 5; r++) begin
            fill_random(1 + int'($urandom_range(0, 7)), 0);
            run_load(pay.size() / 4, r % 3);
        end

        fill_random(2, 0);
        start_i = 1;
        @(negedge clk_i);
        start_i = 0;
        send_byte(8'd2, 0);
        send_byte(8'd0, 0);
        send_byte(pay[0], 0);
        send_byte(pay[1], 0);
        rstn_i = 0;
        @(negedge clk_i);
        check("midrst_ready", 32'(byte_ready_o), 0);
        check("midrst_wen", 32'(mem_wen_o), 0);
        check("midrst_waddr", 32'(mem_waddr_o), 0);
        check("midrst_wdata", mem_wdata_o, 0);
        check("midrst_cpu_rstn", 32'(cpu_rstn_o), 0);
        check("midrst_done", 32'(done_o), 0);
        check("midrst_err", 32'(err_o), 0);
        rstn_i = 1;
        @(negedge clk_i);
        fill_random(1, 0);
        run_load(1, 0);

        fill_random(4096, 1);
        run_load(4096, 0);
        fill_random(3, 0);
        run_load(3, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
